// File: rtl/video_pkg.sv
// Shared video definitions for the capture and transmit timing paths:
// default geometry, coordinate width, lock states and the pixel bundle.
package video_pkg;

  localparam int CW         = 12;
  localparam int HSIZE_DEF  = 640;
  localparam int VSIZE_DEF  = 480;
  localparam int WIDTH_DEF  = 320;
  localparam int HEIGHT_DEF = 240;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  typedef struct packed {
    logic        de;
    coord_t      col;
    coord_t      row;
    logic [23:0] rgb;
  } pix_t;

  function automatic coord_t sat_inc(input coord_t v);
    return (&v) ? v : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/video_rx_meas.sv
// Input sampling, edge detection and geometry measurement for the
// capture path; emits one tagged pixel and a frame boundary per cycle.
module video_rx_meas
  import video_pkg::*;
#(
  parameter int HSIZE = HSIZE_DEF,
  parameter int VSIZE = VSIZE_DEF
) (
  input  logic          clock25,
  input  logic          resetn,
  input  logic [23:0]   vid_d,
  input  logic          vid_de,
  input  logic          vid_hs,
  input  logic          vid_vs,
  output pix_t          pix,
  output logic          bound,
  output logic          frame_bad,
  output logic [CW-1:0] meas_hactive,
  output logic [CW-1:0] meas_vactive
);

  localparam coord_t HS_C = coord_t'(HSIZE);
  localparam coord_t VS_C = coord_t'(VSIZE);

  // line timing is fully carried by DE; hsync adds nothing
  logic unused_hs;
  assign unused_hs = vid_hs;

  logic [23:0] d1_q;
  logic        de1_q, de2_q, vs1_q, vs2_q;
  coord_t      pcol_q, pcol_d, pcol_cur;
  coord_t      lrow_q, lrow_d, lrow_cnt;
  coord_t      mh_q, mh_d, mv_q, mv_d;
  logic        bad_q, bad_d, bad_acc;
  logic        de_rise, de_fall, vs_rise;
  pix_t        pix_q, pix_d;
  logic        bound_q, bound_d;
  logic        fbad_q, fbad_d;

  always_comb begin
    de_rise  = de1_q & ~de2_q;
    de_fall  = ~de1_q & de2_q;
    vs_rise  = vs1_q & ~vs2_q;
    pcol_cur = de_rise ? '0 : pcol_q;
    pcol_d   = de1_q ? sat_inc(pcol_cur) : pcol_q;
    // a line ending on the boundary cycle still counts
    lrow_cnt = de_fall ? sat_inc(lrow_q) : lrow_q;
    lrow_d   = vs_rise ? '0 : lrow_cnt;
    bad_acc  = bad_q
             | (de_fall & (pcol_q != HS_C))
             | (de1_q & vs1_q);
    bad_d    = vs_rise ? 1'b0 : bad_acc;
    fbad_d   = bad_acc | (lrow_cnt != VS_C);
    mh_d     = de_fall ? pcol_q : mh_q;
    mv_d     = vs_rise ? lrow_cnt : mv_q;
    bound_d  = vs_rise;
    pix_d.de  = de1_q;
    pix_d.col = pcol_cur;
    pix_d.row = lrow_q;
    pix_d.rgb = d1_q;
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      d1_q    <= '0;
      de1_q   <= 1'b0;
      de2_q   <= 1'b0;
      vs1_q   <= 1'b0;
      vs2_q   <= 1'b0;
      pcol_q  <= '0;
      lrow_q  <= '0;
      bad_q   <= 1'b0;
      mh_q    <= '0;
      mv_q    <= '0;
      pix_q   <= '0;
      bound_q <= 1'b0;
      fbad_q  <= 1'b0;
    end else begin
      d1_q    <= vid_d;
      de1_q   <= vid_de;
      de2_q   <= de1_q;
      vs1_q   <= vid_vs;
      vs2_q   <= vs1_q;
      pcol_q  <= pcol_d;
      lrow_q  <= lrow_d;
      bad_q   <= bad_d;
      mh_q    <= mh_d;
      mv_q    <= mv_d;
      pix_q   <= pix_d;
      bound_q <= bound_d;
      fbad_q  <= fbad_d;
    end
  end

  assign pix          = pix_q;
  assign bound        = bound_q;
  assign frame_bad    = fbad_q;
  assign meas_hactive = mh_q;
  assign meas_vactive = mv_q;

endmodule

// File: rtl/video_capture.sv
// Video capture front end: lock tracking on measured geometry and
// decimated framebuffer writes while locked.
module video_capture
  import video_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int XDIV   = 2,
  parameter int YDIV   = 2,
  parameter int HSIZE  = HSIZE_DEF,
  parameter int VSIZE  = VSIZE_DEF
) (
  input  logic          clock25,
  input  logic          resetn,
  input  logic [23:0]   vid_d,
  input  logic          vid_de,
  input  logic          vid_hs,
  input  logic          vid_vs,
  output logic          wr_en,
  output logic [CW-1:0] wr_x,
  output logic [CW-1:0] wr_y,
  output logic [23:0]   wr_rgb,
  output logic          frame_start,
  output logic          locked,
  output logic [CW-1:0] meas_hactive,
  output logic [CW-1:0] meas_vactive,
  output logic          err
);

  localparam int     XS   = $clog2(XDIV);
  localparam int     YS   = $clog2(YDIV);
  localparam coord_t XM   = coord_t'(XDIV - 1);
  localparam coord_t YM   = coord_t'(YDIV - 1);
  localparam coord_t WL   = coord_t'(WIDTH);
  localparam coord_t HL   = coord_t'(HEIGHT);

  pix_t pix;
  logic bound, frame_bad;

  video_rx_meas #(
    .HSIZE(HSIZE),
    .VSIZE(VSIZE)
  ) u_meas (
    .clock25     (clock25),
    .resetn      (resetn),
    .vid_d       (vid_d),
    .vid_de      (vid_de),
    .vid_hs      (vid_hs),
    .vid_vs      (vid_vs),
    .pix         (pix),
    .bound       (bound),
    .frame_bad   (frame_bad),
    .meas_hactive(meas_hactive),
    .meas_vactive(meas_vactive)
  );

  state_e state_q;
  logic   locked_q, err_q, fs_q;

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_UNLOCKED;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      fs_q  <= bound;
      err_q <= 1'b0;
      if (bound) begin
        unique case (state_q)
          ST_UNLOCKED: begin
            state_q  <= ST_MEASURE;
            locked_q <= 1'b0;
          end
          ST_MEASURE: if (!frame_bad) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end
          ST_LOCKED: if (frame_bad) begin
            state_q  <= ST_MEASURE;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
          default: begin
            state_q  <= ST_UNLOCKED;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  logic        wr_en_q, wr_en_d;
  coord_t      wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [23:0] wr_rgb_q, wr_rgb_d;

  // keep the first pixel of every XDIV x YDIV block
  always_comb begin
    wr_en_d  = (state_q == ST_LOCKED) & pix.de
             & ((pix.col & XM) == '0)
             & ((pix.row & YM) == '0)
             & ((pix.col >> XS) < WL)
             & ((pix.row >> YS) < HL);
    wr_x_d   = wr_en_d ? (pix.col >> XS) : wr_x_q;
    wr_y_d   = wr_en_d ? (pix.row >> YS) : wr_y_q;
    wr_rgb_d = wr_en_d ? pix.rgb : wr_rgb_q;
  end

  always_ff @(posedge clock25 or negedge resetn) begin
    if (!resetn) begin
      wr_en_q  <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      wr_rgb_q <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      wr_rgb_q <= wr_rgb_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_x        = wr_x_q;
  assign wr_y        = wr_y_q;
  assign wr_rgb      = wr_rgb_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule
